// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit controller.
// Contents:
//   vend_state_e - controller FSM states
//   N_COIN_DEF   - default (and maximum) number of coin types
//   COIN_VAL     - face value of each coin type, indexed by one-hot bit position
//   coin_value() - maps a one-hot coin vector to its face value
package vend_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DISPENSE, CHANGE} vend_state_e;

  localparam int unsigned N_COIN_DEF = 3;
  localparam int unsigned COIN_VAL [N_COIN_DEF] = '{5, 10, 20};

  // OR of the values of the set bits; equals the coin value when the vector is one-hot.
  function automatic int unsigned coin_value(input logic [N_COIN_DEF-1:0] onehot);
    int unsigned val;
    val = 0;
    for (int unsigned i = 0; i < N_COIN_DEF; i++) begin
      if (onehot[i]) val = val | COIN_VAL[i];
    end
    return val;
  endfunction

endpackage

// File: rtl/vend_credit_ctrl_if.sv
// Signal bundle between the credit controller and its surroundings.
// Signals:
//   coin         N_COIN one-hot coin-inserted pulse
//   price        WIDTH  product price
//   cancel       1      refund request (level)
//   change_ready 1      change hopper accepts change
//   credit       WIDTH  accumulated credit
//   dispense     1      one-cycle dispense pulse
//   change       WIDTH  change amount
//   change_valid 1      change offer
//   coin_reject  1      one-cycle coin reject pulse
//   busy         1      controller not idle
// Modports: master = coin acceptor / dispenser side, slave = controller.
interface vend_credit_ctrl_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned N_COIN = vend_pkg::N_COIN_DEF
) ();

  logic [N_COIN-1:0] coin;
  logic [WIDTH-1:0]  price;
  logic              cancel;
  logic              change_ready;
  logic [WIDTH-1:0]  credit;
  logic              dispense;
  logic [WIDTH-1:0]  change;
  logic              change_valid;
  logic              coin_reject;
  logic              busy;

  modport master (
    output coin, price, cancel, change_ready,
    input  credit, dispense, change, change_valid, coin_reject, busy
  );

  modport slave (
    input  coin, price, cancel, change_ready,
    output credit, dispense, change, change_valid, coin_reject, busy
  );

endinterface

// File: rtl/credit_compare.sv
// Unsigned magnitude comparator built from a single WIDTH+1 bit subtraction.
// Ports:
//   i_a, i_b  WIDTH operands
//   o_eq      i_a == i_b
//   o_lt      i_a <  i_b (borrow out of i_a - i_b)
module credit_compare #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_eq,
  output logic             o_lt
);

  logic [WIDTH:0] diff;

  assign diff = {1'b0, i_a} - {1'b0, i_b};
  assign o_lt = diff[WIDTH];
  assign o_eq = (diff[WIDTH-1:0] == '0);

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending-machine credit controller: accumulates coins, dispenses once credit reaches the
// price latched at the first coin, then offers change over a valid/ready handshake.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      vend_credit_ctrl_if slave modport (coin/price/cancel/change_ready in,
//            credit/dispense/change/change_valid/coin_reject/busy out)
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned N_COIN = N_COIN_DEF
) (
  input logic              i_clk,
  input logic              i_rst_n,
  vend_credit_ctrl_if.slave bus
);

  vend_state_e state_q, state_d;
  logic [WIDTH-1:0] credit_q, credit_d;
  logic [WIDTH-1:0] price_q, price_d;
  logic [WIDTH-1:0] change_q, change_d;
  logic             reject_q, reject_d;

  logic [N_COIN_DEF-1:0] coin_ext;
  logic [31:0]           coin_val;
  logic [WIDTH:0]        sum;
  logic                  overflow;
  logic                  coin_any;
  logic                  coin_ok;
  logic                  cmp_eq;
  logic                  cmp_lt;

  credit_compare #(
    .WIDTH (WIDTH)
  ) u_compare (
    .i_a  (credit_q),
    .i_b  (price_q),
    .o_eq (cmp_eq),
    .o_lt (cmp_lt)
  );

  // Accumulator: carry out of the WIDTH+1 bit sum flags overflow; a coin whose face value
  // does not fit in WIDTH bits is an overflow too.
  always_comb begin
    coin_ext             = '0;
    coin_ext[N_COIN-1:0] = bus.coin;
    coin_val             = coin_value(coin_ext);
    sum                  = {1'b0, credit_q} + {1'b0, coin_val[WIDTH-1:0]};
    overflow             = sum[WIDTH] | ((coin_val >> WIDTH) != '0);
    coin_any             = |bus.coin;
    coin_ok              = $onehot(bus.coin) && !overflow;
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    price_d  = price_q;
    change_d = change_q;
    reject_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (coin_ok) begin
          credit_d = sum[WIDTH-1:0];
          price_d  = bus.price;
          state_d  = ACCUM;
        end else begin
          reject_d = coin_any;
        end
      end
      ACCUM: begin
        if (!cmp_lt) begin
          state_d  = DISPENSE;
          reject_d = coin_any;
        end else if (bus.cancel) begin
          change_d = credit_q;
          credit_d = '0;
          state_d  = CHANGE;
          reject_d = coin_any;
        end else if (coin_ok) begin
          credit_d = sum[WIDTH-1:0];
        end else begin
          reject_d = coin_any;
        end
      end
      DISPENSE: begin
        change_d = credit_q - price_q;
        credit_d = '0;
        state_d  = cmp_eq ? IDLE : CHANGE;
        reject_d = coin_any;
      end
      CHANGE: begin
        reject_d = coin_any;
        if (bus.change_ready) begin
          change_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      credit_q <= '0;
      price_q  <= '0;
      change_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      price_q  <= price_d;
      change_q <= change_d;
      reject_q <= reject_d;
    end
  end

  assign bus.credit       = credit_q;
  assign bus.change       = change_q;
  assign bus.coin_reject  = reject_q;
  assign bus.dispense     = (state_q == DISPENSE);
  assign bus.change_valid = (state_q == CHANGE);
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Directed self-checking bench for vend_credit_ctrl (WIDTH=8 and WIDTH=5 instances).
module tb_vend_credit_ctrl;

  logic clk;
  logic rst_n;

  int unsigned n_tests;
  int unsigned n_fail;

  vend_credit_ctrl_if #(.WIDTH(8), .N_COIN(3)) bus8 ();
  vend_credit_ctrl_if #(.WIDTH(5), .N_COIN(3)) bus5 ();

  vend_credit_ctrl #(
    .WIDTH  (8),
    .N_COIN (3)
  ) dut8 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus8)
  );

  vend_credit_ctrl #(
    .WIDTH  (5),
    .N_COIN (3)
  ) dut5 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin8(input logic [2:0] c);
    bus8.coin = c;
    tick();
    bus8.coin = '0;
  endtask

  task automatic coin5(input logic [2:0] c);
    bus5.coin = c;
    tick();
    bus5.coin = '0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus8.coin = '0; bus8.price = 8'd20; bus8.cancel = 1'b0; bus8.change_ready = 1'b0;
    bus5.coin = '0; bus5.price = 5'd31; bus5.cancel = 1'b0; bus5.change_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_credit", bus8.credit, 0);
    check("rst_busy", bus8.busy, 0);
    check("rst_valid", bus8.change_valid, 0);
    check("rst_dispense", bus8.dispense, 0);
    check("rst_reject", bus8.coin_reject, 0);
    check("rst_change", bus8.change, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: 5+5+10 = price, exact dispense, no change
    coin8(3'b001);
    check("t1_credit5", bus8.credit, 5);
    check("t1_busy", bus8.busy, 1);
    coin8(3'b001);
    check("t1_credit10", bus8.credit, 10);
    coin8(3'b010);
    check("t1_credit20", bus8.credit, 20);
    check("t1_no_disp_e0", bus8.dispense, 0);
    tick();
    check("t1_disp_e1", bus8.dispense, 1);
    tick();
    check("t1_disp_off", bus8.dispense, 0);
    check("t1_no_valid", bus8.change_valid, 0);
    check("t1_busy_off", bus8.busy, 0);
    check("t1_credit0", bus8.credit, 0);

    // 2: 10+20 = 30, change 10 held until ready
    coin8(3'b010);
    coin8(3'b100);
    check("t2_credit30", bus8.credit, 30);
    tick();
    check("t2_disp", bus8.dispense, 1);
    tick();
    check("t2_disp_off", bus8.dispense, 0);
    check("t2_valid", bus8.change_valid, 1);
    check("t2_change", bus8.change, 10);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_change", bus8.change, 10);
      check("t2_hold_valid", bus8.change_valid, 1);
    end
    bus8.change_ready = 1'b1;
    tick();
    bus8.change_ready = 1'b0;
    check("t2_valid_off", bus8.change_valid, 0);
    check("t2_idle", bus8.busy, 0);
    check("t2_change0", bus8.change, 0);

    // 3: cancel refunds 15, never dispenses
    coin8(3'b001);
    coin8(3'b010);
    check("t3_credit15", bus8.credit, 15);
    bus8.cancel = 1'b1;
    tick();
    bus8.cancel = 1'b0;
    check("t3_valid", bus8.change_valid, 1);
    check("t3_change", bus8.change, 15);
    check("t3_credit0", bus8.credit, 0);
    check("t3_no_disp", bus8.dispense, 0);
    bus8.change_ready = 1'b1;
    tick();
    bus8.change_ready = 1'b0;
    check("t3_idle", bus8.busy, 0);
    check("t3_no_disp2", bus8.dispense, 0);

    // 4: multi-hot coin rejected in ACCUM; coin in CHANGE rejected
    coin8(3'b001);
    check("t4_credit5", bus8.credit, 5);
    check("t4_no_rej", bus8.coin_reject, 0);
    coin8(3'b011);
    check("t4_rej_multi", bus8.coin_reject, 1);
    check("t4_credit_kept", bus8.credit, 5);
    tick();
    check("t4_rej_pulse", bus8.coin_reject, 0);
    bus8.cancel = 1'b1;
    tick();
    bus8.cancel = 1'b0;
    check("t4_change5", bus8.change, 5);
    coin8(3'b001);
    check("t4_rej_change", bus8.coin_reject, 1);
    check("t4_change_kept", bus8.change, 5);
    check("t4_valid_kept", bus8.change_valid, 1);
    bus8.change_ready = 1'b1;
    tick();
    bus8.change_ready = 1'b0;
    check("t4_idle", bus8.busy, 0);

    // price 0: first coin dispenses next cycle, change = coin value
    bus8.price = 8'd0;
    coin8(3'b010);
    tick();
    check("p0_disp", bus8.dispense, 1);
    tick();
    check("p0_valid", bus8.change_valid, 1);
    check("p0_change", bus8.change, 10);
    bus8.change_ready = 1'b1;
    tick();
    bus8.change_ready = 1'b0;
    check("p0_idle", bus8.busy, 0);

    // 5: WIDTH=5 overflow reject
    coin5(3'b100);
    check("t5_credit20", bus5.credit, 20);
    coin5(3'b010);
    check("t5_credit30", bus5.credit, 30);
    coin5(3'b001);
    check("t5_rej_ovf", bus5.coin_reject, 1);
    check("t5_credit_kept", bus5.credit, 30);
    check("t5_busy", bus5.busy, 1);
    check("t5_no_disp", bus5.dispense, 0);

    // 6: async reset mid-CHANGE, then fresh transaction with new price
    bus8.price = 8'd20;
    coin8(3'b010);
    coin8(3'b100);
    tick();
    tick();
    check("t6_valid", bus8.change_valid, 1);
    check("t6_change10", bus8.change, 10);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", bus8.change_valid, 0);
    check("t6_rst_credit", bus8.credit, 0);
    check("t6_rst_change", bus8.change, 0);
    check("t6_rst_busy", bus8.busy, 0);
    check("t6_rst5_credit", bus5.credit, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus8.price = 8'd10;
    coin8(3'b010);
    check("t6_new_credit", bus8.credit, 10);
    check("t6_new_busy", bus8.busy, 1);
    tick();
    check("t6_new_disp", bus8.dispense, 1);
    tick();
    check("t6_new_idle", bus8.busy, 0);
    check("t6_new_no_valid", bus8.change_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
